pipe_add: RTL

- Parametrised, pipelined successor to the team's 32-bit combinational adder. Used where a single-cycle wide add would limit Fmax, such as the branch-target and address-generation paths in the EX stage, or wide accumulators.
- Performs add or subtract with carry-in, split into STAGES carry-chained slices of WIDTH/STAGES bits each.
- Uses a valid/ready handshake and produces carry, signed-overflow and zero flags.

---
 rtl/pipe_add.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_add.sv
// pipe_add: add/subtract with carry-in, split into STAGES carry-chained slices, valid/ready handshake,
// latency STAGES cycles; whole pipe freezes while out_valid && !out_ready. Optional clamp: PIPE_ADD_SAT_EN.
module pipe_add #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPE_ADD_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  logic              en;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  ps_q [STAGES];

  // Index k holds the inputs seen by stage k; index 0 is the port side.
  logic              v_s  [STAGES+1];
  logic              c_s  [STAGES+1];
  logic [WIDTH-1:0]  a_s  [STAGES+1];
  logic [WIDTH-1:0]  bx_s [STAGES+1];
  logic [WIDTH-1:0]  ps_s [STAGES+1];

  logic [SW:0]       slice_d [STAGES];
  logic [WIDTH-1:0]  ps_d    [STAGES];
  logic [STAGES-1:0] c_d;

  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, ovf_q, zero_q;
  logic              ovf_d, zero_d;

`ifdef PIPE_ADD_SAT_EN
  logic [STAGES-1:0] sat_q;
  logic              sat_s [STAGES+1];
`endif

  assign out_valid = vld_q[STAGES-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    v_s[0]  = in_valid;
    c_s[0]  = sub | cin;
    a_s[0]  = a;
    bx_s[0] = sub ? ~b : b;
    ps_s[0] = '0;
`ifdef PIPE_ADD_SAT_EN
    sat_s[0] = sat;
`endif
    for (int k = 0; k < STAGES; k++) begin
      v_s[k+1]  = vld_q[k];
      c_s[k+1]  = c_q[k];
      a_s[k+1]  = a_q[k];
      bx_s[k+1] = bx_q[k];
      ps_s[k+1] = ps_q[k];
`ifdef PIPE_ADD_SAT_EN
      sat_s[k+1] = sat_q[k];
`endif
    end
  end

  // Each stage fills in its own slice of the partial sum and forwards the slice carry.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_d[k] = {1'b0, a_s[k][k*SW +: SW]} + {1'b0, bx_s[k][k*SW +: SW]} + {{SW{1'b0}}, c_s[k]};
      ps_d[k] = ps_s[k];
      ps_d[k][k*SW +: SW] = slice_d[k][SW-1:0];
      c_d[k] = slice_d[k][SW];
    end
  end

  always_comb begin
    sum_d = ps_d[STAGES-1];
    ovf_d = (a_s[STAGES-1][WIDTH-1] == bx_s[STAGES-1][WIDTH-1]) &&
            (ps_d[STAGES-1][WIDTH-1] != a_s[STAGES-1][WIDTH-1]);
`ifdef PIPE_ADD_SAT_EN
    if (sat_s[STAGES-1] && ovf_d) begin
      sum_d = a_s[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = ~|sum_d;
  end

  // Data registers only load on valid beats so the outputs keep the last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= v_s[k];
        if (v_s[k]) begin
          a_q[k]  <= a_s[k];
          bx_q[k] <= bx_s[k];
          ps_q[k] <= ps_d[k];
          c_q[k]  <= c_d[k];
`ifdef PIPE_ADD_SAT_EN
          sat_q[k] <= sat_s[k];
`endif
        end
      end
      if (v_s[STAGES-1]) begin
        sum_q  <= sum_d;
        cout_q <= c_d[STAGES-1];
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule
